// File: rtl/semaforo_pkg.sv
// Shared types, light codes and head decoding for the traffic-light controller.
package semaforo_pkg;

    localparam int unsigned LIGHT_W = 3;
    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        ALLRED_NS = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_LO = 3'd3,
        LO_GREEN  = 3'd4,
        LO_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_e;

    // Head encoding is {red,yellow,green}
    localparam logic [LIGHT_W-1:0] RED = 3'b100;
    localparam logic [LIGHT_W-1:0] YEL = 3'b010;
    localparam logic [LIGHT_W-1:0] GRN = 3'b001;
    localparam logic [LIGHT_W-1:0] OFF = 3'b000;

    typedef struct packed {
        logic [LIGHT_W-1:0] n_s;
        logic [LIGHT_W-1:0] l_o;
    } heads_t;

    // Light pattern for both heads in a given state; flash only matters in FLASH
    function automatic heads_t decode_heads(input state_e s, input logic fl);
        heads_t h;
        h.n_s = RED;
        h.l_o = RED;
        case (s)
            NS_GREEN:  h.n_s = GRN;
            NS_YELLOW: h.n_s = YEL;
            LO_GREEN:  h.l_o = GRN;
            LO_YELLOW: h.l_o = YEL;
            FLASH: begin
                h.n_s = fl ? YEL : OFF;
                h.l_o = fl ? YEL : OFF;
            end
            default: begin
                h.n_s = RED;
                h.l_o = RED;
            end
        endcase
        return h;
    endfunction

endpackage

// File: rtl/semaforo_if.sv
// Sensor/time-base inputs and signal-head outputs of one intersection.
interface semaforo_if;

    logic                             tick;
    logic                             req_ns;
    logic                             req_lo;
    logic                             emerg;
    logic [semaforo_pkg::LIGHT_W-1:0] n_s;
    logic [semaforo_pkg::LIGHT_W-1:0] l_o;
    logic [semaforo_pkg::PHASE_W-1:0] phase;

    modport master (
        output tick, req_ns, req_lo, emerg,
        input  n_s, l_o, phase
    );

    modport slave (
        input  tick, req_ns, req_lo, emerg,
        output n_s, l_o, phase
    );

endinterface

// File: rtl/semaforo_timer.sv
// Saturating tick counter for phase durations; elapsed = count + 1.
module semaforo_timer #(
    parameter int unsigned TW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    output logic [TW:0] o_elapsed_c
);

    localparam int unsigned  EW  = TW + 1;
    localparam logic [TW-1:0] SAT = '1;

    logic [TW-1:0] r_count;

    // Clear on phase change, otherwise count ticks up to saturation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != SAT)) begin
            r_count <= r_count + TW'(1);
        end
    end

    // One extra bit so a saturated count still reports a larger elapsed value
    assign o_elapsed_c = EW'(r_count) + EW'(1);

endmodule

// File: rtl/semaforo_ctrl.sv
// Timed two-way traffic-light sequencer with demand latches and emergency flash.
module semaforo_ctrl
    import semaforo_pkg::*;
#(
    parameter int unsigned MIN_GREEN = 4,
    parameter int unsigned MAX_GREEN = 10,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALLRED_T  = 1,
    parameter int unsigned TW        = 4
) (
    input  logic       clk,
    input  logic       rst,
    semaforo_if.slave  bus
);

    localparam int unsigned   EW       = TW + 1;
    localparam logic [EW-1:0] L_MIN    = EW'(MIN_GREEN);
    localparam logic [EW-1:0] L_MAX    = EW'(MAX_GREEN);
    localparam logic [EW-1:0] L_YELLOW = EW'(YELLOW_T);
    localparam logic [EW-1:0] L_ALLRED = EW'(ALLRED_T);

    state_e        r_state;
    logic          r_flash;
    logic          r_pend_ns;
    logic          r_pend_lo;
    heads_t        r_heads;

    state_e        w_next_state;
    logic          w_next_flash;
    logic          w_next_pend_ns;
    logic          w_next_pend_lo;
    logic          w_state_chg;
    heads_t        w_heads;
    logic [EW-1:0] w_elapsed;

    semaforo_timer #(.TW(TW)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_state_chg),
        .i_en        (bus.tick),
        .o_elapsed_c (w_elapsed)
    );

    // State, flash phase, demand latches and registered head patterns
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ALLRED_NS;
            r_flash   <= 1'b0;
            r_pend_ns <= 1'b0;
            r_pend_lo <= 1'b0;
            r_heads   <= '{n_s: RED, l_o: RED};
        end else begin
            r_state   <= w_next_state;
            r_flash   <= w_next_flash;
            r_pend_ns <= w_next_pend_ns;
            r_pend_lo <= w_next_pend_lo;
            r_heads   <= w_heads;
        end
    end

    // Next-state, latch and output decode; emergency overrides all timing
    always_comb begin
        w_next_state   = r_state;
        w_next_flash   = 1'b0;
        w_next_pend_ns = r_pend_ns;
        w_next_pend_lo = r_pend_lo;
        w_state_chg    = 1'b0;
        w_heads        = '{n_s: RED, l_o: RED};

        if (bus.emerg) begin
            w_next_state = FLASH;
        end else if (r_state == FLASH) begin
            w_next_state = ALLRED_NS;
        end else if (bus.tick) begin
            case (r_state)
                ALLRED_NS: if (w_elapsed >= L_ALLRED) w_next_state = NS_GREEN;
                NS_GREEN: begin
                    if (r_pend_lo && (((w_elapsed >= L_MIN) && !bus.req_ns) ||
                                      (w_elapsed >= L_MAX)))
                        w_next_state = NS_YELLOW;
                end
                NS_YELLOW: if (w_elapsed >= L_YELLOW) w_next_state = ALLRED_LO;
                ALLRED_LO: if (w_elapsed >= L_ALLRED) w_next_state = LO_GREEN;
                LO_GREEN: begin
                    if (r_pend_ns && (((w_elapsed >= L_MIN) && !bus.req_lo) ||
                                      (w_elapsed >= L_MAX)))
                        w_next_state = LO_YELLOW;
                end
                LO_YELLOW: if (w_elapsed >= L_YELLOW) w_next_state = ALLRED_NS;
                default:   w_next_state = ALLRED_NS;
            endcase
        end

        w_state_chg = (w_next_state != r_state);

        // Flash only toggles while staying in FLASH; it restarts dark on entry
        if ((r_state == FLASH) && bus.emerg)
            w_next_flash = r_flash ^ bus.tick;

        // Latches set on demand, cleared on entry to the served green (clear wins)
        w_next_pend_ns = r_pend_ns | (bus.req_ns && (r_state != NS_GREEN));
        w_next_pend_lo = r_pend_lo | (bus.req_lo && (r_state != LO_GREEN));
        if ((w_next_state == NS_GREEN) && (r_state != NS_GREEN))
            w_next_pend_ns = 1'b0;
        if ((w_next_state == LO_GREEN) && (r_state != LO_GREEN))
            w_next_pend_lo = 1'b0;

        w_heads = decode_heads(w_next_state, w_next_flash);
    end

    assign bus.n_s   = r_heads.n_s;
    assign bus.l_o   = r_heads.l_o;
    assign bus.phase = r_state;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl with a phase-table reference model.
module tb_semaforo_ctrl;

    localparam int MIN_GREEN = 4;
    localparam int MAX_GREEN = 10;
    localparam int YELLOW_T  = 2;
    localparam int ALLRED_T  = 1;
    localparam int TW        = 4;

    logic clk = 1'b0;
    logic rst;

    int vectors     = 0;
    int miscompares = 0;

    semaforo_if bus_if ();

    semaforo_ctrl #(
        .MIN_GREEN (MIN_GREEN),
        .MAX_GREEN (MAX_GREEN),
        .YELLOW_T  (YELLOW_T),
        .ALLRED_T  (ALLRED_T),
        .TW        (TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Time base: a tick every tick_div-th cycle, changed on the falling edge
    int tick_div = 1;
    int tcnt     = 0;
    always @(negedge clk) begin
        tcnt = tcnt + 1;
        bus_if.tick = ((tcnt % tick_div) == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase table, unsaturated tick count) -----
    int m_ph    = 0;
    int m_cnt   = 0;
    bit m_pl    = 0;
    bit m_pn    = 0;
    bit m_fl    = 0;
    bit m_valid = 0;

    function automatic int phase_after(input int ph, input int e, input bit tk, input bit em,
                                       input bit rn, input bit rl, input bit pl, input bit pn);
        int fixed_dur[6];
        bit waiting;
        bit own;
        fixed_dur = '{ALLRED_T, 0, YELLOW_T, ALLRED_T, 0, YELLOW_T};
        if (em) return 6;
        if (ph == 6) return 0;
        if (!tk) return ph;
        if (ph == 1 || ph == 4) begin
            waiting = (ph == 1) ? pl : pn;
            own     = (ph == 1) ? rn : rl;
            if (waiting && ((e >= MIN_GREEN && !own) || e >= MAX_GREEN)) return ph + 1;
            return ph;
        end
        if (e >= fixed_dur[ph]) return (ph + 1) % 6;
        return ph;
    endfunction

    function automatic logic [2:0] head(input int ph, input bit fl, input bit is_ns);
        logic [2:0] ns_tab [6];
        logic [2:0] lo_tab [6];
        ns_tab = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b100, 3'b100};
        lo_tab = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010};
        if (ph == 6) return fl ? 3'b010 : 3'b000;
        return is_ns ? ns_tab[ph] : lo_tab[ph];
    endfunction

    always @(posedge clk) begin
        int nph;
        bit nl;
        bit nn;
        if (rst) begin
            m_ph = 0; m_cnt = 0; m_pl = 0; m_pn = 0; m_fl = 0; m_valid = 1;
        end else if (m_valid) begin
            nph = phase_after(m_ph, m_cnt + 1, bus_if.tick, bus_if.emerg,
                              bus_if.req_ns, bus_if.req_lo, m_pl, m_pn);
            nl = (m_pl || (bus_if.req_lo && m_ph != 4)) && !(nph == 4 && m_ph != 4);
            nn = (m_pn || (bus_if.req_ns && m_ph != 1)) && !(nph == 1 && m_ph != 1);
            m_fl  = (m_ph == 6 && bus_if.emerg) ? (m_fl ^ bus_if.tick) : 1'b0;
            m_cnt = (nph != m_ph) ? 0 : m_cnt + int'(bus_if.tick);
            m_ph  = nph;
            m_pl  = nl;
            m_pn  = nn;
        end
    end

    // Every-cycle comparison against the model, plus the red-safety invariant
    always @(negedge clk) begin
        if (m_valid) begin
            check("phase", 32'(bus_if.phase), 32'(m_ph));
            check("n_s", 32'(bus_if.n_s), 32'(head(m_ph, m_fl, 1'b1)));
            check("l_o", 32'(bus_if.l_o), 32'(head(m_ph, m_fl, 1'b0)));
            check("timer", 32'(dut.u_timer.r_count), 32'((m_cnt > 15) ? 15 : m_cnt));
            check("pend_lo", 32'(dut.r_pend_lo), 32'(m_pl));
            check("pend_ns", 32'(dut.r_pend_ns), 32'(m_pn));
            if (bus_if.phase != 3'd6) begin
                vectors++;
                assert (bus_if.n_s == 3'b100 || bus_if.l_o == 3'b100)
                else begin
                    miscompares++;
                    $display("FAIL safety: n_s=%b l_o=%b both non-red (t=%0t)",
                             bus_if.n_s, bus_if.l_o, $time);
                end
            end
        end
    end

    // ---------------- stimulus helpers -----------------------------------------
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string name);
        int n;
        n = 0;
        while (bus_if.phase !== 3'(ph) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(bus_if.phase), 32'(ph));
    endtask

    task automatic measure(input int ph, output int n);
        n = 0;
        while (bus_if.phase === 3'(ph) && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus_if.req_ns = 1'b0;
        bus_if.req_lo = 1'b0;
        bus_if.emerg  = 1'b0;

        // 1: no demand, rest in NS green
        do_reset();
        check("t1_rst_phase", 32'(bus_if.phase), 0);
        check("t1_rst_ns", 32'(bus_if.n_s), 32'b100);
        check("t1_rst_lo", 32'(bus_if.l_o), 32'b100);
        @(negedge clk);
        check("t1_green_ns", 32'(bus_if.n_s), 32'b001);
        repeat (49) @(negedge clk);
        check("t1_green_held", 32'(bus_if.phase), 1);

        // 2: cross demand, minimum green
        bus_if.req_lo = 1'b1;
        do_reset();
        wait_phase(1, 5, "t2_enter_green");
        measure(1, n); check("t2_green_len", 32'(n), 4);
        measure(2, n); check("t2_yellow_len", 32'(n), 2);
        measure(3, n); check("t2_allred_len", 32'(n), 1);
        check("t2_lo_green_phase", 32'(bus_if.phase), 4);
        check("t2_lo_green_lo", 32'(bus_if.l_o), 32'b001);
        check("t2_pend_lo_clr", 32'(dut.r_pend_lo), 0);
        bus_if.req_lo = 1'b0;

        // 3: both demanding, maximum green
        bus_if.req_lo = 1'b1;
        bus_if.req_ns = 1'b1;
        do_reset();
        wait_phase(1, 5, "t3_enter_green");
        measure(1, n); check("t3_ns_green_max", 32'(n), 10);
        measure(2, n); check("t3_yellow_len", 32'(n), 2);
        measure(3, n); check("t3_allred_len", 32'(n), 1);
        measure(4, n); check("t3_lo_green_max", 32'(n), 10);
        bus_if.req_lo = 1'b0;
        bus_if.req_ns = 1'b0;

        // 4: slow time base scales every duration by 3
        tick_div = 3;
        bus_if.req_lo = 1'b1;
        do_reset();
        wait_phase(1, 20, "t4_enter_green");
        measure(1, n); check("t4_green_x3", 32'(n), 12);
        measure(2, n); check("t4_yellow_x3", 32'(n), 6);
        measure(3, n); check("t4_allred_x3", 32'(n), 3);
        tick_div = 1;
        bus_if.req_lo = 1'b0;

        // 5: emergency during NS yellow
        bus_if.req_lo = 1'b1;
        do_reset();
        wait_phase(2, 20, "t5_enter_yellow");
        bus_if.emerg = 1'b1;
        @(negedge clk);
        check("t5_flash_phase", 32'(bus_if.phase), 6);
        check("t5_flash_off", 32'(bus_if.n_s), 32'b000);
        @(negedge clk);
        check("t5_flash_on_ns", 32'(bus_if.n_s), 32'b010);
        check("t5_flash_on_lo", 32'(bus_if.l_o), 32'b010);
        @(negedge clk);
        check("t5_flash_off2", 32'(bus_if.l_o), 32'b000);
        @(negedge clk);
        check("t5_flash_on2", 32'(bus_if.n_s), 32'b010);
        bus_if.emerg = 1'b0;
        @(negedge clk);
        check("t5_exit_phase", 32'(bus_if.phase), 0);
        check("t5_exit_ns", 32'(bus_if.n_s), 32'b100);
        @(negedge clk);
        check("t5_back_green", 32'(bus_if.phase), 1);
        bus_if.req_lo = 1'b0;

        // 6: reset in the middle of LO green
        bus_if.req_lo = 1'b1;
        do_reset();
        wait_phase(4, 40, "t6_enter_lo_green");
        bus_if.req_lo = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_phase", 32'(bus_if.phase), 0);
        check("t6_rst_ns", 32'(bus_if.n_s), 32'b100);
        check("t6_rst_lo", 32'(bus_if.l_o), 32'b100);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/semaforo_ctrl.md
Name: semaforo_ctrl

Overview:
- Sequential two-way traffic-light controller. It drives the north-south (n_s) and east-west (l_o) signal heads of one intersection.
- It sequences green → yellow → all-red phases with tick-based timers.
- It serves vehicle-sensor requests with minimum and maximum green times, and supports an emergency flashing-yellow mode.
- It sits above the combinational Semaforo decoder and replaces its static light decision with timed sequencing.

Parameters:
- MIN_GREEN, 4, minimum green duration in ticks (≥1).
- MAX_GREEN, 10, maximum green duration in ticks while the cross direction waits (≥MIN_GREEN).
- YELLOW_T, 2, yellow duration in ticks (≥1).
- ALLRED_T, 1, all-red clearance duration in ticks (≥1).
- TW, 4, timer width in bits; must hold MAX_GREEN.

Ports:
- clk  in  1  system clock; all logic rises on its posedge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  time-base enable pulse, one clk wide; timers advance only on tick=1.
- req_ns  in  1  vehicle present on the n_s approach (level).
- req_lo  in  1  vehicle present on the l_o approach (level).
- emerg  in  1  emergency/fault request; forces flashing mode (level).
- n_s  out  3  n_s head {red,yellow,green}, one-hot or all-off.
- l_o  out  3  l_o head {red,yellow,green}, one-hot or all-off.
- phase  out  3  current state code, for debug and verification.

Behaviour:
- Fixed decisions: one clock domain (clk); rst is synchronous and active-high. rst=1 at a posedge takes priority over every other input.
- Reset values:
  - state=ALLRED_NS, timer=0, pend_ns=0, pend_lo=0, flash=0.
  - n_s=3'b100, l_o=3'b100, phase=ALLRED_NS code.
- Outputs are Moore: decoded from registered state and flash only. They change in the same cycle the state register updates; no extra latency.
- Timer:
  - Cleared to 0 on every state change.
  - Increments on tick while the state is held; saturates at 2^TW−1.
  - "Elapsed" = timer+1 evaluated on a tick cycle.
- Pending latches:
  - pend_lo is set by req_lo=1 in any state except LO_GREEN, and cleared on entry to LO_GREEN.
  - pend_ns is the symmetric latch for req_ns and NS_GREEN.
  - Set and clear in the same cycle → clear wins.
- States and transitions (all transitions occur only on tick=1 unless noted):
  - ALLRED_NS (n_s=100, l_o=100): elapsed≥ALLRED_T → NS_GREEN.
  - NS_GREEN (n_s=001, l_o=100):
    - Stay while pend_lo=0 (rest in green, unbounded).
    - With pend_lo=1: go to NS_YELLOW when (elapsed≥MIN_GREEN and req_ns=0) or elapsed≥MAX_GREEN.
  - NS_YELLOW (n_s=010, l_o=100): elapsed≥YELLOW_T → ALLRED_LO.
  - ALLRED_LO (100/100): elapsed≥ALLRED_T → LO_GREEN.
  - LO_GREEN and LO_YELLOW: mirror NS_GREEN and NS_YELLOW with pend_ns and req_lo; LO_YELLOW → ALLRED_NS.
  - FLASH:
    - Entered from any state on the cycle after emerg=1 is sampled, independent of tick.
    - Both heads show yellow when flash=1 and all-off when flash=0; flash toggles on each tick.
    - When emerg=0 is sampled, go to ALLRED_NS with the timer cleared and flash=0.
- Simultaneous events:
  - emerg beats the timer transition.
  - req and tick in the same cycle: the req is latched and the transition uses the pre-edge pend value.
- Safety invariant: n_s and l_o are never both non-red outside FLASH, in any cycle including reset.
- Reset mid-phase returns to ALLRED_NS within one cycle; no yellow is skipped-to.

Decomposition:
- semaforo_pkg holds:
  - state enum (ALLRED_NS=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_LO=3, LO_GREEN=4, LO_YELLOW=5, FLASH=6).
  - Light constants RED=3'b100, YEL=3'b010, GRN=3'b001, OFF=3'b000.
- One sub-module, semaforo_timer: a TW-bit tick counter with clear, enable and saturation, exposing the elapsed count.
- FSM, latches and output decode stay in semaforo_ctrl.

Test Plan:
1. Reset then tick=1 every cycle, no requests:
   - Required: 100/100 for 1 cycle, then NS_GREEN (001/100) held indefinitely (checked for 50 cycles).
2. In NS_GREEN, hold req_lo=1, req_ns=0:
   - Required: green lasts exactly 4 ticks, then NS_YELLOW 2 ticks, ALLRED_LO 1 tick, then LO_GREEN (100/001).
   - pend_lo reads 0 after LO_GREEN entry.
3. req_lo=1 and req_ns=1 held:
   - Required: NS_GREEN extends to exactly 10 ticks (MAX_GREEN) before yellow.
4. tick pulsed every 3rd cycle:
   - Required: state durations scale ×3 in clk cycles; the timer holds value between ticks.
5. emerg=1 asserted mid-NS_YELLOW:
   - Required: FLASH next cycle, both heads alternating 010/000 on each tick.
   - After emerg=0: ALLRED_NS, then NS_GREEN.
6. rst=1 for one cycle during LO_GREEN:
   - Required: 100/100 and phase=0 the following cycle.
   - Across all tests, an assertion checks the never-both-non-red invariant outside FLASH.
